alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 44 ++++
 rtl/alu_seq_fifo.sv | 53 +++++
 rtl/alu_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared widths, ALU opcode constants, sequencer FSM encoding
// and the layout of one queued command.
package alu_seq_pkg;

    localparam int DATA_W = 16;
    localparam int TAG_W  = 4;
    localparam int OP_W   = 4;
    localparam int CNT_W  = 16;

    // Opcodes understood by the external ALU. Codes 1100-1111 are undefined;
    // the sequencer forwards them untouched and the ALU answers 0 / zero=1.
    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
    localparam logic [OP_W-1:0] OP_NOT = 4'b0101;
    localparam logic [OP_W-1:0] OP_SHL = 4'b0110;
    localparam logic [OP_W-1:0] OP_SHR = 4'b0111;
    localparam logic [OP_W-1:0] OP_SRA = 4'b1000;
    localparam logic [OP_W-1:0] OP_ROL = 4'b1001;
    localparam logic [OP_W-1:0] OP_ROR = 4'b1010;
    localparam logic [OP_W-1:0] OP_MUL = 4'b1011;

    // Sequencer states: wait for work, drive the ALU, let it settle, present.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } seqState_t;

    // One command as it sits in the FIFO.
    typedef struct packed {
        logic              chain;
        logic [TAG_W-1:0]  tag;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmdEntry_t;

    localparam int CMD_W = $bits(cmdEntry_t);

endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: small synchronous FIFO holding pending ALU commands.
// Pointers carry one extra wrap bit so full and empty are told apart without
// a separate occupancy counter. Push is ignored when full, pop when empty.
module alu_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic             w_doPush;
    logic             w_doPop;

    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                      (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_rdata  = r_mem[r_rdPtr[AW-1:0]];

    // Write the incoming entry at the tail and advance the pointers; a
    // simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr[AW-1:0]] <= i_wdata;
                r_wrPtr <= r_wrPtr + {{AW{1'b0}}, 1'b1};
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: queues ALU commands, issues them one at a time to an external
// registered ALU and returns the results in command order.
// Optional feature macro: ALU_SEQ_CHAIN_EN -- keeps the last captured result
// so a command flagged with cmd_chain uses it as operand A.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int CMD_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    input  logic              cmd_chain,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_carry,
    output logic              rsp_ovf,
    output logic [TAG_W-1:0]  rsp_tag,

    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_enable,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_ovf,

    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);

    cmdEntry_t         w_pushEntry;
    cmdEntry_t         w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic [DATA_W-1:0] w_operandA;

    seqState_t         r_state;
    logic              r_aluEnable;
    logic [OP_W-1:0]   r_aluOp;
    logic [DATA_W-1:0] r_aluA;
    logic [DATA_W-1:0] r_aluB;
    logic [TAG_W-1:0]  r_issueTag;
    logic              r_rspValid;
    logic [DATA_W-1:0] r_rspResult;
    logic              r_rspZero;
    logic              r_rspCarry;
    logic              r_rspOvf;
    logic [TAG_W-1:0]  r_rspTag;
    logic [CNT_W-1:0]  r_opsDone;

    assign w_pushEntry = '{chain: cmd_chain, tag: cmd_tag, op: cmd_op,
                           a: cmd_a, b: cmd_b};

    alu_seq_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (cmd_valid),
        .i_wdata (w_pushEntry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // The head leaves the FIFO when an idle FSM picks it up, or on the
    // response handshake so back-to-back commands issue without a gap.
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) ||
                    ((r_state == ST_RESP) && rsp_ready));

`ifdef ALU_SEQ_CHAIN_EN
    logic [DATA_W-1:0] r_lastResult;

    // Remember the most recent captured result for chained commands; the next
    // pop always happens after this capture, so it is already up to date.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastResult <= '0;
        end else if (r_state == ST_WAIT) begin
            r_lastResult <= alu_result;
        end
    end

    assign w_operandA = w_head.chain ? r_lastResult : w_head.a;
`else
    logic w_unusedChain;

    assign w_unusedChain = w_head.chain;
    assign w_operandA    = w_head.a;
`endif

    // Sequencer FSM: latches operands on pop, pulses alu_enable for the one
    // ISSUE cycle, captures the ALU outputs at the end of WAIT and holds the
    // response until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_aluEnable <= 1'b0;
            r_aluOp     <= '0;
            r_aluA      <= '0;
            r_aluB      <= '0;
            r_issueTag  <= '0;
            r_rspValid  <= 1'b0;
            r_rspResult <= '0;
            r_rspZero   <= 1'b0;
            r_rspCarry  <= 1'b0;
            r_rspOvf    <= 1'b0;
            r_rspTag    <= '0;
            r_opsDone   <= '0;
        end else begin
            r_aluEnable <= 1'b0;
            if (w_pop) begin
                r_aluEnable <= 1'b1;
                r_aluOp     <= w_head.op;
                r_aluA      <= w_operandA;
                r_aluB      <= w_head.b;
                r_issueTag  <= w_head.tag;
            end
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_rspResult <= alu_result;
                    r_rspZero   <= alu_zero;
                    r_rspCarry  <= alu_carry;
                    r_rspOvf    <= alu_ovf;
                    r_rspTag    <= r_issueTag;
                    r_rspValid  <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_opsDone  <= r_opsDone + {{(CNT_W-1){1'b0}}, 1'b1};
                        r_state    <= w_empty ? ST_IDLE : ST_ISSUE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = !w_full;
    assign rsp_valid  = r_rspValid;
    assign rsp_result = r_rspResult;
    assign rsp_zero   = r_rspZero;
    assign rsp_carry  = r_rspCarry;
    assign rsp_ovf    = r_rspOvf;
    assign rsp_tag    = r_rspTag;
    assign alu_op     = r_aluOp;
    assign alu_a      = r_aluA;
    assign alu_b      = r_aluB;
    assign alu_enable = r_aluEnable;
    assign busy       = (r_state != ST_IDLE) || !w_empty;
    assign ops_done   = r_opsDone;

endmodule
